ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the 5-stage MIPS pipeline. Holds the program counter and drives it to the instruction memory. Captures the returned instruction into the IF/ID pipeline register. Computes the next PC from sequential, branch, jump and jump-register redirects that the decode stage resolves. Branches resolve in D and the architecture has one delay slot, so there is no flush path.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset and start of text segment.
- PC_LIMIT, 32'h0000_3FFC, highest legal fetch address; 1024 words from PC_RESET.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- stall  in  1  from hazard unit; holds the PC and the IF/ID register.
- npc_op  in  2  next-PC select: 00 pc+4, 01 branch, 10 j/jal, 11 jr.
- br_cond  in  1  branch comparison result from D; used only when npc_op=01.
- jr_target  in  32  forwarded rs value from D; used only when npc_op=11.
- pc_f  out  32  current fetch address, sent to instruction memory.
- instr_f  in  32  instruction word from instruction memory (combinational on pc_f).
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc8_d  out  32  pc_d+8, link address for jal/jalr.
- exc_d  out  1  IF/ID fetch-address fault flag.

## Operation
- PC register pc_f. Next-PC logic uses the IF/ID contents, because the redirecting instruction sits in D:
  - 00: pc_f+4.
  - 01: if br_cond, pc_d+4+(sign_ext(instr_d[15:0])<<2); otherwise pc_f+4.
  - 10: {pc_d[31:28]+carry-free, i.e. (pc_d+4)[31:28], instr_d[25:0], 2'b00}.
  - 11: jr_target.
- The delay slot is implicit. While the branch is in D, the slot instruction is being fetched at pc_f. It is captured normally, and the redirect takes effect on the PC of the following fetch.
- Fetch fault: pc_f[1:0]!=0, or pc_f<PC_RESET, or pc_f>PC_LIMIT.
  - On a fault, the IF/ID register captures instr_d=0 (nop) and exc_d=1. pc_d still captures pc_f, for EPC.
  - Fetch continues from the computed next PC; this block does not stop on a fault.
- IF/ID update when not stalled: instr_d<=fault?0:instr_f, pc_d<=pc_f, pc8_d<=pc_f+8, exc_d<=fault.
- Priority per edge: reset > stall > normal update.
  - On stall, pc_f and all IF/ID outputs hold.
  - A redirect presented during a stall is ignored. The stalled branch stays in D and re-presents its redirect when the stall releases.
- Arithmetic: all additions are 32-bit modulo 2^32. 0xFFFF_FFFC+4 wraps to 0, which is then flagged as a fault. The branch offset is sign-extended to 32 bits before the shift.
- Invalid npc_op combinations do not exist; all four codes are defined.

## Timing
- Reset values: pc_f=PC_RESET, instr_d=0, pc_d=0, pc8_d=0, exc_d=0.
- pc_f is registered and valid from the cycle after reset deasserts. instr_f returns in the same cycle (memory is combinational) and is captured at the next edge.
- Fetch-to-D latency: 1 cycle.
- Redirect latency: a redirect seen in cycle n (branch in D) sets pc_f to the target at edge n+1. Exactly one delay-slot instruction enters D between the branch and its target.
- Reset asserted mid-stall or mid-redirect: the next edge yields the reset values, and any pending redirect is lost.
- Stall asserted for k cycles: pc_f and IF/ID are unchanged for k edges. The first unstalled edge behaves as if the stall never occurred.
- No combinational path from instr_f to pc_f. The next-PC logic depends only on registers plus npc_op, br_cond and jr_target.

## Test plan
- Reset then 4 free-running cycles, memory returning 0x2408_0001 at every address -> pc_f sequence 0x3000,0x3004,0x3008,0x300C; pc_d lags by one cycle; pc8_d=pc_d+8; exc_d=0.
- beq in D at pc_d=0x3008 with imm=0xFFFE, npc_op=01, br_cond=1 -> slot at 0x300C is captured, then pc_f=0x3004. Same case with br_cond=0 -> pc_f=0x3010.
- j in D at pc_d=0x3010 with instr_index=0x0000C40 -> pc_f becomes 0x0000_3100 after the slot fetch. jr with jr_target=0x3020 -> pc_f=0x3020.
- stall high for 3 cycles while a j is in D -> pc_f and IF/ID frozen for 3 edges; the jump is taken on the first unstalled edge.
- jr_target=0x3002 (misaligned), and separately jr_target=0x4000 (past PC_LIMIT) -> next D capture has instr_d=0, exc_d=1, pc_d=faulting address.
- reset asserted the same cycle as stall=1 and npc_op=10 -> pc_f=0x3000 and all IF/ID outputs 0 on the next edge.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, next-PC select and the IF/ID pipeline register.
// Redirects are resolved from the IF/ID contents, so the delay slot falls out naturally.
module ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_cond,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_f,
    input  logic [31:0] instr_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        exc_d
);

    logic [31:0] pc_seq;
    logic [31:0] pc_d4;
    logic [31:0] br_off;
    logic [31:0] pc_next;
    logic        fault;

    // Only registered state and the D-stage controls feed pc_next; instr_f never does.
    always_comb begin
        pc_seq = pc_f + 32'd4;
        pc_d4  = pc_d + 32'd4;
        br_off = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
        case (npc_op)
            2'b00:   pc_next = pc_seq;
            2'b01:   pc_next = br_cond ? (pc_d4 + br_off) : pc_seq;
            2'b10:   pc_next = {pc_d4[31:28], instr_d[25:0], 2'b00};
            default: pc_next = jr_target;
        endcase
    end

    assign fault = (pc_f[1:0] != 2'b00) || (pc_f < PC_RESET) || (pc_f > PC_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= PC_RESET;
            instr_d <= 32'd0;
            pc_d    <= 32'd0;
            pc8_d   <= 32'd0;
            exc_d   <= 1'b0;
        end else if (!stall) begin
            // A faulting fetch still advances; pc_d keeps the bad address for EPC.
            pc_f    <= pc_next;
            instr_d <= fault ? 32'd0 : instr_f;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
            exc_d   <= fault;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed test-plan steps, then randomized cycles checked against
// an arithmetic reference model of the fetch stage.
module tb_ifu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic        br_cond = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] pc_f;
    logic [31:0] instr_f = 32'd0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        exc_d;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc = 32'h0000_3000;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pcd = 32'd0;
    logic [31:0] m_pc8 = 32'd0;
    logic        m_exc = 1'b0;

    localparam logic [31:0] ADDI = 32'h2408_0001;
    localparam logic [31:0] BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] JMP  = 32'h0800_0C40;

    ifu dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_cond(br_cond),
        .jr_target(jr_target), .pc_f(pc_f), .instr_f(instr_f), .instr_d(instr_d),
        .pc_d(pc_d), .pc8_d(pc8_d), .exc_d(exc_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, compare all outputs.
    task automatic tick(input logic rst, input logic st, input logic [1:0] op,
                        input logic bc, input logic [31:0] jt, input logic [31:0] ins);
        logic [31:0] n_pc, n_instr, n_pcd, n_pc8;
        logic        n_exc, flt;
        int          off;
        reset = rst; stall = st; npc_op = op; br_cond = bc; jr_target = jt; instr_f = ins;
        n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_pc8 = m_pc8; n_exc = m_exc;
        if (rst) begin
            n_pc = 32'h3000; n_instr = 0; n_pcd = 0; n_pc8 = 0; n_exc = 0;
        end else if (!st) begin
            flt = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h3FFC);
            off = $signed(m_instr[15:0]);
            case (op)
                2'd0: n_pc = m_pc + 4;
                2'd1: n_pc = bc ? m_pcd + 4 + 32'(off * 4) : m_pc + 4;
                2'd2: n_pc = ((m_pcd + 4) & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
                default: n_pc = jt;
            endcase
            n_instr = flt ? 32'd0 : ins;
            n_pcd = m_pc;
            n_pc8 = m_pc + 8;
            n_exc = flt;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pc8 = n_pc8; m_exc = n_exc;
        check("model_pc_f", pc_f, m_pc);
        check("model_instr_d", instr_d, m_instr);
        check("model_pc_d", pc_d, m_pcd);
        check("model_pc8_d", pc8_d, m_pc8);
        check("model_exc_d", {31'd0, exc_d}, {31'd0, m_exc});
    endtask

    initial begin
        logic [31:0] jt, ins;
        // reset state
        tick(1, 0, 2'd0, 0, 0, ADDI);
        check("rst_pc_f", pc_f, 32'h3000);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_instr_d", instr_d, 32'h0);
        // free-running sequential fetch
        tick(0, 0, 2'd0, 0, 0, ADDI);
        check("seq1_pc_f", pc_f, 32'h3004);
        check("seq1_pc_d", pc_d, 32'h3000);
        check("seq1_pc8_d", pc8_d, 32'h3008);
        check("seq1_instr_d", instr_d, ADDI);
        tick(0, 0, 2'd0, 0, 0, ADDI);
        check("seq2_pc_f", pc_f, 32'h3008);
        // beq taken, backward offset
        tick(0, 0, 2'd0, 0, 0, BEQ);
        check("beq_fetch_pc_f", pc_f, 32'h300C);
        check("beq_in_d", instr_d, BEQ);
        tick(0, 0, 2'd1, 1, 0, ADDI);
        check("beq_taken_pc_f", pc_f, 32'h3004);
        check("beq_slot_pc_d", pc_d, 32'h300C);
        // beq not taken
        tick(0, 0, 2'd0, 0, 0, ADDI);
        tick(0, 0, 2'd0, 0, 0, BEQ);
        tick(0, 0, 2'd1, 0, 0, ADDI);
        check("beq_nt_pc_f", pc_f, 32'h3010);
        // j, then jr
        tick(0, 0, 2'd0, 0, 0, JMP);
        check("j_in_d_pc_d", pc_d, 32'h3010);
        tick(0, 0, 2'd2, 0, 0, ADDI);
        check("j_pc_f", pc_f, 32'h3100);
        check("j_slot_pc_d", pc_d, 32'h3014);
        tick(0, 0, 2'd3, 0, 32'h3020, ADDI);
        check("jr_pc_f", pc_f, 32'h3020);
        // stall for 3 cycles with j in D
        tick(0, 0, 2'd0, 0, 0, JMP);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 2'd2, 0, 0, ADDI);
            check("stall_pc_f", pc_f, 32'h3024);
            check("stall_pc_d", pc_d, 32'h3020);
            check("stall_instr_d", instr_d, JMP);
        end
        tick(0, 0, 2'd2, 0, 0, ADDI);
        check("unstall_j_pc_f", pc_f, 32'h3100);
        check("unstall_pc_d", pc_d, 32'h3024);
        // misaligned and out-of-range fetch faults
        tick(0, 0, 2'd3, 0, 32'h3002, ADDI);
        tick(0, 0, 2'd0, 0, 0, ADDI);
        check("misal_pc_d", pc_d, 32'h3002);
        check("misal_instr_d", instr_d, 32'h0);
        check("misal_exc_d", {31'd0, exc_d}, 32'd1);
        tick(0, 0, 2'd3, 0, 32'h4000, ADDI);
        tick(0, 0, 2'd0, 0, 0, ADDI);
        check("limit_pc_d", pc_d, 32'h4000);
        check("limit_exc_d", {31'd0, exc_d}, 32'd1);
        // top of address space wraps to 0, still faulting
        tick(0, 0, 2'd3, 0, 32'hFFFF_FFFC, ADDI);
        tick(0, 0, 2'd0, 0, 0, ADDI);
        check("wrap_pc_f", pc_f, 32'h0);
        tick(0, 0, 2'd0, 0, 0, ADDI);
        check("wrap_exc_d", {31'd0, exc_d}, 32'd1);
        tick(0, 0, 2'd3, 0, 32'h3000, ADDI);
        // reset together with stall and a pending jump
        tick(0, 0, 2'd0, 0, 0, JMP);
        tick(1, 1, 2'd2, 0, 0, ADDI);
        check("rst_mid_pc_f", pc_f, 32'h3000);
        check("rst_mid_instr_d", instr_d, 32'h0);
        check("rst_mid_pc8_d", pc8_d, 32'h0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            jt = ($urandom_range(0, 9) == 0) ? $urandom()
                 : 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
            case ($urandom_range(0, 3))
                0: ins = BEQ;
                1: ins = JMP;
                2: ins = {16'h1000, 16'($urandom())};
                default: ins = $urandom();
            endcase
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), jt, ins);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
